// File: rtl/aggregation_drain_pkg.sv
// Shared widths and FSM encoding for the aggregation drain stage.
package aggregation_drain_pkg;

  localparam int unsigned defDataWidth = 32;
  localparam int unsigned defPvadd     = 128;
  localparam int unsigned defK         = 1024;

  localparam int unsigned ROW_ADDR_W = $clog2(defK);
  localparam int unsigned ROW_CNT_W  = $clog2(defK + 1);
  localparam int unsigned BEAT_W     = defDataWidth * defPvadd;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_DONE = 2'd2
  } drainState_t;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry register FIFO; the head slot is presented directly as the registered output beat.
module drain_skid_fifo #(
  parameter int unsigned entryW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [entryW-1:0] pushData,
  input  logic              pop,
  output logic [entryW-1:0] headData,
  output logic              full,
  output logic              empty
);

  logic [entryW-1:0] slot0;
  logic [entryW-1:0] slot1;
  logic [1:0]        cnt;

  // slot0 is always the head; pops shift slot1 forward
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= pushData;
          else             slot1 <= pushData;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= pushData;
          end else begin
            slot0 <= slot1;
            slot1 <= pushData;
          end
        end
        default: ;
      endcase
    end
  end

  assign headData = slot0;
  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);

endmodule

// File: rtl/aggregation_drain.sv
// Drains completed rows from the row buffer into a valid/ready beat stream.
// Optional build macro DRAIN_RELU_EN clamps negative lanes to zero at FIFO write.
module aggregation_drain
  import aggregation_drain_pkg::*;
#(
  parameter int unsigned dataWidth = defDataWidth,
  parameter int unsigned pvadd     = defPvadd,
  parameter int unsigned k         = defK,
  localparam int unsigned rowAddrW = $clog2(k),
  localparam int unsigned rowCntW  = $clog2(k + 1),
  localparam int unsigned beatW    = dataWidth * pvadd
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [rowCntW-1:0]  num_rows,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [rowAddrW-1:0] rd_addr,
  input  logic [beatW-1:0]    rd_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [beatW-1:0]    m_data,
  output logic [rowAddrW-1:0] m_row,
  output logic                m_last
);

  localparam int unsigned entryW = 1 + rowAddrW + beatW;

  drainState_t         state;
  drainState_t         stateNext;
  logic [rowCntW-1:0]  numRowsQ;
  logic [rowAddrW-1:0] rdAddrQ;
  logic [rowAddrW-1:0] rdRow;
  logic                rdValid;
  logic                rdLast;
  logic                doneNext;
  logic                lastIssue;
  logic                pop;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [1:0]          occ;
  logic [1:0]          occNext;
  logic [beatW-1:0]    pushBeat;
  logic [entryW-1:0]   head;

  // Credit counts occupancy after this cycle's pop, so a steady drain issues every cycle
  always_comb begin
    stateNext = state;
    doneNext  = 1'b0;
    rd_en     = 1'b0;
    lastIssue = 1'b0;
    pop       = !fifoEmpty && m_ready;
    occ       = fifoFull ? 2'd2 : (fifoEmpty ? 2'd0 : 2'd1);
    occNext   = occ + {1'b0, rdValid} - {1'b0, pop};
    case (state)
      IDLE: begin
        if (start) stateNext = (num_rows == '0) ? WAIT_DONE : RUN;
      end
      RUN: begin
        rd_en     = (3'(occ) + 3'(rdValid)) < (3'd2 + 3'(pop));
        lastIssue = rd_en && (rdAddrQ == rowAddrW'(numRowsQ - rowCntW'(1)));
        if (lastIssue) stateNext = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (occNext == 2'd0) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      numRowsQ <= '0;
      rdAddrQ  <= '0;
      rdRow    <= '0;
      rdValid  <= 1'b0;
      rdLast   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= stateNext;
      done    <= doneNext;
      rdValid <= rd_en;
      if (state == IDLE && start) begin
        numRowsQ <= num_rows;
        rdAddrQ  <= '0;
      end
      if (rd_en) begin
        rdAddrQ <= rdAddrQ + rowAddrW'(1);
        rdRow   <= rdAddrQ;
        rdLast  <= lastIssue;
      end
    end
  end

  always_comb begin
    pushBeat = rd_data;
`ifdef DRAIN_RELU_EN
    for (int unsigned l = 0; l < pvadd; l++) begin
      if (rd_data[l*dataWidth + dataWidth - 1]) pushBeat[l*dataWidth +: dataWidth] = '0;
    end
`endif
  end

  drain_skid_fifo #(.entryW(entryW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rdValid),
    .pushData ({rdLast, rdRow, pushBeat}),
    .pop      (pop),
    .headData (head),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign {m_last, m_row, m_data} = head;
  assign m_valid = !fifoEmpty;
  assign busy    = (state != IDLE);
  assign rd_addr = rdAddrQ;

endmodule

// File: tb/tb_aggregation_drain.sv
// Directed bench for aggregation_drain with a 1-cycle-latency row buffer model.
// Honors DRAIN_RELU_EN for the expected lane values.
module tb_aggregation_drain;
  import aggregation_drain_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [ROW_CNT_W-1:0]  numRows = '0;
  logic                  mReady = 1'b0;
  logic [BEAT_W-1:0]     rdData = '0;
  logic                  busy, done, rdEn, mValid, mLast;
  logic [ROW_ADDR_W-1:0] rdAddr, mRow;
  logic [BEAT_W-1:0]     mData;

  int total = 0;
  int bad   = 0;
  int patMode = 0;

  int rowQ[$];
  int lastQ[$];
  int dataBad, stallBad, stalls, doneCnt, doneCyc, firstValid, lastHs, busyCyc, rdEnCnt, addrBad, maxOut;
  int lane0, lane1;

  aggregation_drain dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(numRows), .busy(busy), .done(done),
    .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData), .m_valid(mValid), .m_ready(mReady),
    .m_data(mData), .m_row(mRow), .m_last(mLast)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] srcLane(int row, int lane);
    if (patMode == 1) return (lane % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0005;
    return 32'(row);
  endfunction

  function automatic logic [31:0] expLane(int row, int lane);
    if (patMode == 1 && (lane % 2 == 0)) begin
`ifdef DRAIN_RELU_EN
      return 32'h0000_0000;
`else
      return 32'hFFFF_FFFF;
`endif
    end
    return srcLane(row, lane);
  endfunction

  function automatic logic [BEAT_W-1:0] srcBeat(int row);
    logic [BEAT_W-1:0] v;
    for (int l = 0; l < int'(defPvadd); l++) v[l*32 +: 32] = srcLane(row, l);
    return v;
  endfunction

  function automatic logic [BEAT_W-1:0] expBeat(int row);
    logic [BEAT_W-1:0] v;
    for (int l = 0; l < int'(defPvadd); l++) v[l*32 +: 32] = expLane(row, l);
    return v;
  endfunction

  // Row buffer: data appears one cycle after the read
  always @(posedge clk) if (rdEn) rdData <= srcBeat(int'(rdAddr));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic startDrain(input int n);
    start = 1'b1;
    numRows = ROW_CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs cycle by cycle after a start edge, recording beats and protocol statistics
  task automatic collect(input int readyMode, input int restartCyc, input int stopBeats, input int maxCyc);
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pl = 1'b0;
    logic [BEAT_W-1:0] pd = '0;
    logic [ROW_ADDR_W-1:0] prw = '0;
    int issued = 0;
    int popped = 0;
    rowQ.delete(); lastQ.delete();
    dataBad = 0; stallBad = 0; stalls = 0; doneCnt = 0; doneCyc = -1; firstValid = -1;
    lastHs = -1; busyCyc = 0; addrBad = 0; maxOut = 0; lane0 = 0; lane1 = 0;
    for (int c = 0; c < maxCyc; c++) begin
      mReady = (readyMode == 0) ? 1'b1 : 1'(((c % 4) == 0) || ((c % 4) == 3));
      start = (c == restartCyc);
      if (c == restartCyc) numRows = ROW_CNT_W'(3);
      #1;
      if (pv && !pr) begin
        stalls++;
        if (!mValid || mData !== pd || mRow !== prw || mLast !== pl) stallBad++;
      end
      if (mValid && firstValid < 0) firstValid = c;
      if (busy) busyCyc++;
      if (done) begin doneCnt++; if (doneCyc < 0) doneCyc = c; end
      if (issued - popped > maxOut) maxOut = issued - popped;
      if (rdEn) begin if (int'(rdAddr) != issued) addrBad++; issued++; end
      if (mValid && mReady) begin
        if (rowQ.size() == 0) begin lane0 = int'(mData[31:0]); lane1 = int'(mData[63:32]); end
        if (mData !== expBeat(rowQ.size())) dataBad++;
        rowQ.push_back(int'(mRow));
        lastQ.push_back(int'(mLast));
        lastHs = c;
        popped++;
      end
      pv = mValid; pr = mReady; pd = mData; prw = mRow; pl = mLast;
      @(posedge clk); #1;
      start = 1'b0;
      if (stopBeats > 0 && rowQ.size() >= stopBeats) break;
      if (doneCyc >= 0 && c >= doneCyc + 3) break;
    end
    rdEnCnt = issued;
    start = 1'b0;
  endtask

  task automatic chkRows(input string tag, input int n);
    chk({tag, "_beats"}, rowQ.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_row%0d", tag, i), (i < rowQ.size()) ? rowQ[i] : -1, i);
      chk($sformatf("%s_last%0d", tag, i), (i < lastQ.size()) ? lastQ[i] : -1, (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rden"}, int'(rdEn), 0);
    chk({tag, "_rdaddr"}, int'(rdAddr), 0);
    chk({tag, "_mvalid"}, int'(mValid), 0);
    chk({tag, "_mrow"}, int'(mRow), 0);
    chk({tag, "_mlast"}, int'(mLast), 0);
    chk({tag, "_mdata_nz"}, int'(mData != '0), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chkIdleOutputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back drain of 4 rows
    startDrain(4);
    collect(0, -1, 0, 40);
    chkRows("t1", 4);
    chk("t1_first_valid", firstValid, 2);
    chk("t1_last_hs", lastHs, 5);
    chk("t1_done_cyc", doneCyc, 6);
    chk("t1_done_cnt", doneCnt, 1);
    chk("t1_busy_cyc", busyCyc, 6);
    chk("t1_rden_cnt", rdEnCnt, 4);
    chk("t1_addr_bad", addrBad, 0);
    chk("t1_data_bad", dataBad, 0);

    // Zero rows
    startDrain(0);
    collect(0, -1, 0, 20);
    chk("t2_beats", rowQ.size(), 0);
    chk("t2_rden_cnt", rdEnCnt, 0);
    chk("t2_first_valid", firstValid, -1);
    chk("t2_done_cyc", doneCyc, 1);
    chk("t2_done_cnt", doneCnt, 1);
    chk("t2_busy_cyc", busyCyc, 1);

    // Backpressure 1,0,0,1
    startDrain(8);
    collect(1, -1, 0, 100);
    chkRows("t3", 8);
    chk("t3_data_bad", dataBad, 0);
    chk("t3_stalls_seen", int'(stalls > 0), 1);
    chk("t3_stall_stable", stallBad, 0);
    chk("t3_outstanding_le2", int'(maxOut <= 2), 1);
    chk("t3_done_cnt", doneCnt, 1);
    chk("t3_addr_bad", addrBad, 0);

    // Second start while busy is ignored
    startDrain(5);
    collect(0, 2, 0, 40);
    chkRows("t4", 5);
    chk("t4_rden_cnt", rdEnCnt, 5);
    chk("t4_done_cnt", doneCnt, 1);
    chk("t4_data_bad", dataBad, 0);

    // Reset after two beats of six, then a fresh 2-row drain
    startDrain(6);
    collect(0, -1, 2, 40);
    chk("t5_beats_before_rst", rowQ.size(), 2);
    rst = 1'b0;
    #1;
    chkIdleOutputs("t5_rst");
    doneCnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    chk("t5_done_in_rst", doneCnt, 0);
    chk("t5_mvalid_in_rst", int'(mValid), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    startDrain(2);
    collect(0, -1, 0, 30);
    chkRows("t5", 2);
    chk("t5_done_cnt", doneCnt, 1);
    chk("t5_data_bad", dataBad, 0);

    // Sign-bit lanes
    patMode = 1;
    startDrain(2);
    collect(0, -1, 0, 30);
`ifdef DRAIN_RELU_EN
    chk("t6_lane0", lane0, 0);
`else
    chk("t6_lane0", lane0, -1);
`endif
    chk("t6_lane1", lane1, 5);
    chk("t6_data_bad", dataBad, 0);
    chk("t6_beats", rowQ.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
